// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Two-master sequencer for a sync-read block RAM.
package dmem_pkg;

  localparam int MEM_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        legal;
  } cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Master request/response and memory-port bundle for dmem_arbiter.
// arb: arbiter side; host: masters plus memory side.
interface dmem_arbiter_if;

  logic        M0_Req;
  logic        M0_Write;
  logic [31:0] M0_Addr;
  logic [31:0] M0_WData;
  logic        M0_Ack;
  logic [31:0] M0_RData;
  logic        M0_Stall;

  logic        M1_Req;
  logic        M1_Write;
  logic [31:0] M1_Addr;
  logic [31:0] M1_WData;
  logic        M1_Ack;
  logic [31:0] M1_RData;

  logic        AccErr;
  logic [31:0] MemAddr;
  logic [31:0] MemDataIn;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemDataOut;

  modport arb (
    input  M0_Req, M0_Write, M0_Addr, M0_WData,
    input  M1_Req, M1_Write, M1_Addr, M1_WData,
    input  MemDataOut,
    output M0_Ack, M0_RData, M0_Stall,
    output M1_Ack, M1_RData,
    output AccErr,
    output MemAddr, MemDataIn, MemRead, MemWrite
  );

  modport host (
    output M0_Req, M0_Write, M0_Addr, M0_WData,
    output M1_Req, M1_Write, M1_Addr, M1_WData,
    output MemDataOut,
    input  M0_Ack, M0_RData, M0_Stall,
    input  M1_Ack, M1_RData,
    input  AccErr,
    input  MemAddr, MemDataIn, MemRead, MemWrite
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Winner select; DMEM_ARB_STARVE_GUARD_EN adds an M1 starvation guard.
// Without the macro M0 has strict priority.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arb_pick
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic m0Req,
  input  logic m1Req,
  output logic win
);

  logic [2:0] cnt;
  logic       starved;

  assign starved = (cnt == 3'(STARVE_LIMIT)) && m1Req;

  always_comb begin
    win = M1;
    if (m0Req && !starved)
      win = M0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (idle) begin
      if (!m1Req || win == M1)
        cnt <= '0;
      else if (m0Req)
        cnt <= cnt + 3'd1;
    end
  end

endmodule
`else
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic m0Req,
  input  logic m1Req,
  output logic win
);

  always_comb begin
    win = M1;
    if (m0Req || !m1Req)
      win = M0;
  end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: IDLE -> ISSUE -> ACK sequencer.
// Optional starvation guard via DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_WIDTH = MEM_WIDTH_DEF
`ifdef DMEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic     clk,
  input  logic     reset_n,
  dmem_arbiter_if.arb bus
);

  state_t      state;
  state_t      nxt;
  cmd_t        cmd;
  cmd_t        newCmd;
  logic        win;
  logic        idle;
  logic        grant;
  logic        ackNow;
  logic        memRd;
  logic        memWr;
  logic [31:0] rdNow;
  logic [31:0] hold0;
  logic [31:0] hold1;

  assign idle  = (state == IDLE);
  assign grant = idle && (bus.M0_Req || bus.M1_Req);

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk   (clk),
    .rst_n (reset_n),
    .idle  (idle),
    .m0Req (bus.M0_Req),
    .m1Req (bus.M1_Req),
    .win   (win)
  );
`else
  dmem_arb_pick u_pick (
    .m0Req (bus.M0_Req),
    .m1Req (bus.M1_Req),
    .win   (win)
  );
`endif

  always_comb begin
    newCmd.id    = win;
    newCmd.wr    = bus.M0_Write;
    newCmd.addr  = bus.M0_Addr;
    newCmd.wdata = bus.M0_WData;
    if (win == M1) begin
      newCmd.wr    = bus.M1_Write;
      newCmd.addr  = bus.M1_Addr;
      newCmd.wdata = bus.M1_WData;
    end
    newCmd.legal = (newCmd.addr[31:MEM_WIDTH] == '0);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (grant) nxt = ISSUE;
      ISSUE:   nxt = ACK;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cmd   <= '0;
      memRd <= 1'b0;
      memWr <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      state <= nxt;
      memRd <= grant && newCmd.legal && !newCmd.wr;
      memWr <= grant && newCmd.legal && newCmd.wr;
      if (grant)
        cmd <= newCmd;
      if (ackNow && cmd.id == M0)
        hold0 <= rdNow;
      if (ackNow && cmd.id == M1)
        hold1 <= rdNow;
    end
  end

  // Read data arrives straight from the RAM in ACK; hold regs keep it after.
  assign ackNow = (state == ACK);
  assign rdNow  = (cmd.legal && !cmd.wr) ? bus.MemDataOut : '0;

  always_comb begin
    bus.M0_Ack   = ackNow && (cmd.id == M0);
    bus.M1_Ack   = ackNow && (cmd.id == M1);
    bus.M0_RData = bus.M0_Ack ? rdNow : hold0;
    bus.M1_RData = bus.M1_Ack ? rdNow : hold1;
    bus.M0_Stall = bus.M0_Req && !bus.M0_Ack;
    bus.AccErr   = ackNow && !cmd.legal;
  end

  assign bus.MemAddr   = cmd.addr;
  assign bus.MemDataIn = cmd.wdata;
  assign bus.MemRead   = memRd;
  assign bus.MemWrite  = memWr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a sync-read RAM model.
// Build with DMEM_ARB_STARVE_GUARD_EN to exercise the guard.
module tb_dmem_arbiter;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  dmem_arbiter_if bus ();

  dmem_arbiter u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [31:0] rdq;

  always @(posedge clk) begin
    if (bus.MemWrite)
      mem[bus.MemAddr[10:2]] <= bus.MemDataIn;
    if (bus.MemRead)
      rdq <= mem[bus.MemAddr[10:2]];
  end

  assign bus.MemDataOut = rdq;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input bit m, input bit rq,
                        input bit wr, input logic [31:0] a,
                        input logic [31:0] d);
    if (m) begin
      bus.M1_Req   = rq;
      bus.M1_Write = wr;
      bus.M1_Addr  = a;
      bus.M1_WData = d;
    end else begin
      bus.M0_Req   = rq;
      bus.M0_Write = wr;
      bus.M0_Addr  = a;
      bus.M0_WData = d;
    end
  endtask

  // One access from IDLE; returns latency, data, error, enable cycles.
  task automatic xfer(input bit m, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat,
                      output logic err, output int nEn);
    bit done;
    done = 0;
    lat  = 0;
    nEn  = 0;
    rd   = 'x;
    err  = 'x;
    setReq(m, 1'b1, wr, a, d);
    for (int i = 1; i <= 10 && !done; i++) begin
      tick();
      if (bus.MemRead || bus.MemWrite)
        nEn++;
      if (m ? bus.M1_Ack : bus.M0_Ack) begin
        done = 1;
        lat  = i;
        rd   = m ? bus.M1_RData : bus.M0_RData;
        err  = bus.AccErr;
      end
    end
    setReq(m, 1'b0, 1'b0, '0, '0);
    if (!done)
      chk("xfer_timeout", 32'd0, 32'd1);
    tick();
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          nEn;
  int          m0At;
  int          m1At;
  int          m1Acks;
  int          m0Acks;
  logic [31:0] rd0;
  logic [31:0] rd1;

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    #12;
    chk("rst_ack0", {31'd0, bus.M0_Ack}, 32'd0);
    chk("rst_memrd", {31'd0, bus.MemRead}, 32'd0);
    chk("rst_maddr", bus.MemAddr, 32'd0);
    chk("rst_rdata1", bus.M1_RData, 32'd0);
    reset_n = 1'b1;
    tick();

    // M0 write, traced cycle by cycle
    setReq(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("wr_stall_t0", {31'd0, bus.M0_Stall}, 32'd1);
    chk("wr_mw_t0", {31'd0, bus.MemWrite}, 32'd0);
    tick();
    chk("wr_mw_t1", {31'd0, bus.MemWrite}, 32'd1);
    chk("wr_mr_t1", {31'd0, bus.MemRead}, 32'd0);
    chk("wr_addr_t1", bus.MemAddr, 32'h10);
    chk("wr_data_t1", bus.MemDataIn, 32'hDEADBEEF);
    chk("wr_stall_t1", {31'd0, bus.M0_Stall}, 32'd1);
    chk("wr_ack_t1", {31'd0, bus.M0_Ack}, 32'd0);
    tick();
    chk("wr_ack_t2", {31'd0, bus.M0_Ack}, 32'd1);
    chk("wr_mw_t2", {31'd0, bus.MemWrite}, 32'd0);
    chk("wr_stall_t2", {31'd0, bus.M0_Stall}, 32'd0);
    chk("wr_rdata_t2", bus.M0_RData, 32'd0);
    chk("wr_err_t2", {31'd0, bus.AccErr}, 32'd0);
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    chk("wr_ack_t3", {31'd0, bus.M0_Ack}, 32'd0);

    xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, err, nEn);
    chk("rd_lat", lat, 32'd2);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", {31'd0, err}, 32'd0);
    chk("rd_en", nEn, 32'd1);
    chk("rd_hold", bus.M0_RData, 32'hDEADBEEF);

    xfer(1'b1, 1'b1, 32'h20, 32'h11111111, rd, lat, err, nEn);
    chk("m1_wr_lat", lat, 32'd2);
    xfer(1'b1, 1'b1, 32'h30, 32'h22222222, rd, lat, err, nEn);
    xfer(1'b0, 1'b1, 32'h40, 32'h0, rd, lat, err, nEn);

    // simultaneous reads: M0 first, M1 three cycles later
    m0At = 0;
    m1At = 0;
    setReq(1'b0, 1'b1, 1'b0, 32'h20, '0);
    setReq(1'b1, 1'b1, 1'b0, 32'h30, '0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.M0_Ack) begin
        m0At = i;
        rd0  = bus.M0_RData;
        chk("both_m1hold", bus.M1_RData, 32'd0);
        bus.M0_Req = 1'b0;
      end
      if (bus.M1_Ack) begin
        m1At = i;
        rd1  = bus.M1_RData;
        bus.M1_Req = 1'b0;
      end
    end
    chk("both_m0at", m0At, 32'd2);
    chk("both_m1at", m1At, 32'd5);
    chk("both_rd0", rd0, 32'h11111111);
    chk("both_rd1", rd1, 32'h22222222);

    xfer(1'b1, 1'b0, 32'h800, '0, rd, lat, err, nEn);
    chk("ill_lat", lat, 32'd2);
    chk("ill_rdata", rd, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_en", nEn, 32'd0);

    // reset during ISSUE of a write
    setReq(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
    tick();
    chk("rstw_mw", {31'd0, bus.MemWrite}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstw_mw_drop", {31'd0, bus.MemWrite}, 32'd0);
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    tick();
    chk("rstw_ack0", {31'd0, bus.M0_Ack}, 32'd0);
    chk("rstw_rd0", bus.M0_RData, 32'd0);
    chk("rstw_maddr", bus.MemAddr, 32'd0);
    chk("rstw_mdin", bus.MemDataIn, 32'd0);
    chk("rstw_err", {31'd0, bus.AccErr}, 32'd0);
    chk("rstw_ren", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    m0Acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.M0_Ack)
        m0Acks++;
    end
    chk("rstw_noack", m0Acks, 32'd0);
    xfer(1'b0, 1'b0, 32'h40, '0, rd, lat, err, nEn);
    chk("rstw_memkept", rd, 32'd0);

    // M1 withdraws while M0 is busy
    m1Acks = 0;
    nEn    = 0;
    setReq(1'b0, 1'b1, 1'b0, 32'h10, '0);
    setReq(1'b1, 1'b1, 1'b1, 32'h20, 32'h55555555);
    tick();
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    if (bus.MemRead || bus.MemWrite)
      nEn++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MemRead || bus.MemWrite)
        nEn++;
      if (bus.M1_Ack)
        m1Acks++;
      if (bus.M0_Ack)
        bus.M0_Req = 1'b0;
    end
    chk("drop_m1ack", m1Acks, 32'd0);
    chk("drop_en", nEn, 32'd1);
    xfer(1'b1, 1'b0, 32'h20, '0, rd, lat, err, nEn);
    chk("drop_memkept", rd, 32'h11111111);

    // M0 holds Req continuously while M1 waits
    m0Acks = 0;
    m1Acks = 0;
    m1At   = -1;
    setReq(1'b0, 1'b1, 1'b0, 32'h10, '0);
    setReq(1'b1, 1'b1, 1'b0, 32'h20, '0);
    for (int i = 0; i < 200 && m0Acks < 50 && m1Acks == 0; i++) begin
      tick();
      if (bus.M0_Ack)
        m0Acks++;
      if (bus.M1_Ack) begin
        m1Acks++;
        m1At = m0Acks;
      end
    end
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
`ifdef DMEM_ARB_STARVE_GUARD_EN
    chk("starve_m1_after", m1At, 32'd4);
`else
    chk("starve_m0acks", m0Acks, 32'd50);
    chk("starve_m1none", m1Acks, 32'd0);
`endif
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter and sequencer for the shared word-addressed data memory (sync-read block RAM, 1-cycle read latency). Master 0 is the pipeline MEM stage; master 1 is a secondary agent (DMA/debug loader). Grants one access at a time, registers the command onto the memory port, returns read data with a one-cycle Ack, and filters out-of-range addresses. Fixed priority to master 0, with an optional starvation guard for master 1.

Parameters:
MEM_WIDTH, 11, number of low address bits that may be non-zero; any set bit in Addr[31:MEM_WIDTH] makes the access illegal.
STARVE_LIMIT, 4, number of consecutive master-0 grants allowed while master 1 waits (used only with the guard).

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset_n  in  1  asynchronous active-low reset.
M0_Req  in  1  master 0 request; held with its command until M0_Ack.
M0_Write  in  1  1 = write, 0 = read.
M0_Addr  in  32  byte address.
M0_WData  in  32  write data.
M0_Ack  out  1  one-cycle completion pulse.
M0_RData  out  32  read data, valid when M0_Ack is high.
M0_Stall  out  1  M0_Req high and M0_Ack low (combinational).
M1_Req, M1_Write, M1_Addr, M1_WData, M1_Ack, M1_RData  same as the master-0 equivalents, for master 1.
AccErr  out  1  one-cycle pulse with Ack when the completed access was illegal.
MemAddr  out  32  registered address to memory.
MemDataIn  out  32  registered write data.
MemRead  out  1  registered read enable.
MemWrite  out  1  registered write enable.
MemDataOut  in  32  memory read data; valid the cycle after MemRead.

Behaviour:
- Reset, asynchronous on reset_n low: state = IDLE; all outputs and internal registers = 0.
- Reset mid-access aborts the access: no Ack is produced, and MemRead/MemWrite drop to 0 immediately.
- FSM states: IDLE -> ISSUE -> ACK -> IDLE.
- IDLE:
  - Does nothing if no Req is high.
  - Otherwise picks a winner. M0 wins if M0_Req is high; else M1 wins.
  - Latches the winner's id, Write, Addr, WData and legal flag, where legal = (Addr[31:MEM_WIDTH] == 0).
  - Moves to ISSUE.
- ISSUE:
  - MemAddr/MemDataIn hold the latched values.
  - If legal: MemRead = ~Write and MemWrite = Write, for exactly this one cycle.
  - If illegal: both enables stay 0 and memory is untouched.
  - Moves to ACK.
- ACK:
  - Winner's Ack = 1 for this one cycle.
  - Winner's RData: MemDataOut for a legal read; 0 for a write or an illegal access.
  - The other master's RData holds its previous value.
  - AccErr = ~legal.
  - Memory enables = 0. Moves to IDLE.
- Latency: Req seen in IDLE at cycle t -> memory command in t+1 -> Ack/RData in t+2. Minimum spacing between back-to-back accesses is 3 cycles.
- Handshake rules:
  - A master keeps Req and its command stable until its Ack.
  - After Ack it must drop Req or present a new command by the next IDLE cycle. A Req still high in IDLE is treated as a new request.
  - Dropping Req before the grant cancels the request with no effect.
  - Changes after the grant are ignored because the command is latched, and the Ack still pulses.
- Simultaneous requests are resolved in IDLE only; the loser waits and its Stall (M0) or held Req (M1) persists.
- Address and data are passed through unmodified; the memory does its own word indexing.

Optional Feature:
Macro DMEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter increments on each M0 grant made while M1_Req is high.
  - The counter clears on any M1 grant or when M1_Req is low in IDLE.
  - When counter == STARVE_LIMIT and both masters request, M1 wins.
  - The counter resets to 0.
- Undefined: strict M0 priority, no counter logic. M1 can starve indefinitely.

Decomposition:
- Shared package dmem_pkg:
  - MEM_WIDTH default.
  - FSM state encoding (IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2).
  - Master-id constants M0 = 1'b0, M1 = 1'b1.
- One natural sub-module, dmem_arb_pick: combinational winner select plus the optional starvation counter. It keeps the priority policy swappable. The FSM and the command/response registers stay in the top module.

Test Plan:
- M0 write then read (Addr=0x00000010, WData=0xDEADBEEF):
  - Write: MemWrite high exactly one cycle, at t+1.
  - Read: M0_Ack at t+2 with M0_RData=0xDEADBEEF, AccErr=0.
  - M0_Stall high for 2 cycles per access.
- M0 and M1 request in the same cycle (both reads): M0 is served first. M1_Ack arrives 3 cycles after M0_Ack, with M1's data. M1_RData is unchanged during M0's access.
- Illegal address (M1 read, Addr=0x00000800, MEM_WIDTH=11): MemRead and MemWrite never asserted; M1_Ack with M1_RData=0 and AccErr=1 at t+2.
- Reset asserted during ISSUE of an M0 write: MemWrite drops asynchronously, no M0_Ack, and after release the FSM is in IDLE with all outputs 0.
- M0 holds Req continuously while M1 requests, with DMEM_ARB_STARVE_GUARD_EN defined: M1 granted after exactly 4 M0 grants. Without the macro, M1 is never granted within 50 accesses.
- M1 drops Req before a grant (M0 busy): no M1 access is issued and no M1_Ack pulses.
